// File: rtl/vliw_execute_pkg.sv
// Shared constants for the VLIW execute stage: opcodes, register names, slot count.
package vliw_execute_pkg;

  localparam int NSLOT     = 3;
  localparam int OP_W      = 4;
  localparam int REG_IDX_W = 4;

  // Opcode encodings. 0x8..0xE are undefined and treated as illegal.
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD = 4'h1;
  localparam logic [OP_W-1:0] OP_INC  = 4'h2;
  localparam logic [OP_W-1:0] OP_DEC  = 4'h3;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h4;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h5;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h6;
  localparam logic [OP_W-1:0] OP_CLR  = 4'h7;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // Architectural register names. reg0 is hardwired to zero.
  localparam logic [REG_IDX_W-1:0] REG0  = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG1  = 4'd1;
  localparam logic [REG_IDX_W-1:0] REG2  = 4'd2;
  localparam logic [REG_IDX_W-1:0] REG3  = 4'd3;
  localparam logic [REG_IDX_W-1:0] REG4  = 4'd4;
  localparam logic [REG_IDX_W-1:0] REG5  = 4'd5;
  localparam logic [REG_IDX_W-1:0] REG6  = 4'd6;
  localparam logic [REG_IDX_W-1:0] REG7  = 4'd7;
  localparam logic [REG_IDX_W-1:0] REG8  = 4'd8;
  localparam logic [REG_IDX_W-1:0] REG9  = 4'd9;
  localparam logic [REG_IDX_W-1:0] REG10 = 4'd10;
  localparam logic [REG_IDX_W-1:0] REG11 = 4'd11;
  localparam logic [REG_IDX_W-1:0] REG12 = 4'd12;
  localparam logic [REG_IDX_W-1:0] REG13 = 4'd13;
  localparam logic [REG_IDX_W-1:0] REG14 = 4'd14;
  localparam logic [REG_IDX_W-1:0] REG15 = 4'd15;

endpackage

// File: rtl/vliw_alu_slot.sv
// Combinational unary ALU for one VLIW slot: opcode, operand and immediate in;
// result, a "this opcode writes its destination" flag and a legality flag out.
module vliw_alu_slot
  import vliw_execute_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              writes,
  output logic              legal
);

  // Decode the opcode and compute the unary result; arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    result = operand;
    writes = 1'b0;
    legal  = 1'b1;
    case (op)
      OP_NOP:  ;
      OP_HALT: ;
      OP_LOAD: begin result = imm;                  writes = 1'b1; end
      OP_INC:  begin result = operand + DATA_W'(1); writes = 1'b1; end
      OP_DEC:  begin result = operand - DATA_W'(1); writes = 1'b1; end
      OP_NOT:  begin result = ~operand;             writes = 1'b1; end
      OP_SHL:  begin result = operand << 1;         writes = 1'b1; end
      OP_SHR:  begin result = operand >> 1;         writes = 1'b1; end
      OP_CLR:  begin result = '0;                   writes = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/vliw_execute.sv
// Execute/writeback stage of the 3-slot VLIW pipeline. Holds the register file,
// applies one unary op per slot and retires the whole bundle every cycle.
// There is no valid/ready handshake: a bundle is consumed on every rising edge
// unless the stage is halted, in which case the bundle is dropped.
module vliw_execute
  import vliw_execute_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OP_W-1:0]      d2e_instpipe1,
  input  logic [OP_W-1:0]      d2e_instpipe2,
  input  logic [OP_W-1:0]      d2e_instpipe3,
  input  logic [REG_IDX_W-1:0] d2e_destpipe1,
  input  logic [REG_IDX_W-1:0] d2e_destpipe2,
  input  logic [REG_IDX_W-1:0] d2e_destpipe3,
  input  logic [DATA_W-1:0]    d2e_datapipe1,
  input  logic [DATA_W-1:0]    d2e_datapipe2,
  input  logic [DATA_W-1:0]    d2e_datapipe3,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic                 halted,
  output logic                 e2d_flush,
  output logic                 illegal_op,
  output logic                 wr_conflict,
  output logic [CNT_W-1:0]     retire_count
);

  logic [DATA_W-1:0]    regs [NREG];

  logic [OP_W-1:0]      slot_op      [NSLOT];
  logic [REG_IDX_W-1:0] slot_dest    [NSLOT];
  logic [DATA_W-1:0]    slot_imm     [NSLOT];
  logic [DATA_W-1:0]    slot_operand [NSLOT];
  logic [DATA_W-1:0]    slot_result  [NSLOT];
  logic [NSLOT-1:0]     slot_writes;
  logic [NSLOT-1:0]     slot_legal;
  logic [NSLOT-1:0]     slot_we;
  logic [NSLOT-1:0]     slot_retire;
  logic [NSLOT-1:0]     slot_halt;

  logic                 any_illegal;
  logic                 any_halt;
  logic                 any_conflict;
  logic [1:0]           bundle_retired;

  assign slot_op[0]   = d2e_instpipe1;
  assign slot_op[1]   = d2e_instpipe2;
  assign slot_op[2]   = d2e_instpipe3;
  assign slot_dest[0] = d2e_destpipe1;
  assign slot_dest[1] = d2e_destpipe2;
  assign slot_dest[2] = d2e_destpipe3;
  assign slot_imm[0]  = d2e_datapipe1;
  assign slot_imm[1]  = d2e_datapipe2;
  assign slot_imm[2]  = d2e_datapipe3;

  // Every slot reads the register file as it stood at the start of the cycle,
  // so slots never observe each other's results within one bundle.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    assign slot_operand[g] = regs[slot_dest[g]];

    vliw_alu_slot #(.DATA_W(DATA_W)) u_alu (
      .op      (slot_op[g]),
      .operand (slot_operand[g]),
      .imm     (slot_imm[g]),
      .result  (slot_result[g]),
      .writes  (slot_writes[g]),
      .legal   (slot_legal[g])
    );

    assign slot_we[g]     = slot_writes[g] && (slot_dest[g] != REG0);
    assign slot_retire[g] = slot_legal[g] && (slot_op[g] != OP_NOP);
    assign slot_halt[g]   = (slot_op[g] == OP_HALT);
  end

  assign any_illegal    = ~&slot_legal;
  assign any_halt       = |slot_halt;
  assign bundle_retired = {1'b0, slot_retire[0]} + {1'b0, slot_retire[1]} + {1'b0, slot_retire[2]};

  // Two or more writing slots aimed at the same (non-zero) register.
  assign any_conflict =
      (slot_we[0] && slot_we[1] && (slot_dest[0] == slot_dest[1])) ||
      (slot_we[0] && slot_we[2] && (slot_dest[0] == slot_dest[2])) ||
      (slot_we[1] && slot_we[2] && (slot_dest[1] == slot_dest[2]));

  assign e2d_flush = halted;

  // Register file writeback, event pulses, halt latch, retire counter and debug read.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      dbg_data     <= '0;
      halted       <= 1'b0;
      illegal_op   <= 1'b0;
      wr_conflict  <= 1'b0;
      retire_count <= '0;
    end else begin
      // Debug read sees the state before this edge's writes; reg0 is never written.
      dbg_data    <= regs[dbg_addr];
      illegal_op  <= !halted && any_illegal;
      wr_conflict <= !halted && any_conflict;
      if (!halted) begin
        // Ascending slot order: the later assignment wins, so slot3 beats slot2 beats slot1.
        for (int s = 0; s < NSLOT; s++) begin
          if (slot_we[s]) regs[slot_dest[s]] <= slot_result[s];
        end
        retire_count <= retire_count + CNT_W'(bundle_retired);
        if (any_halt) halted <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vliw_execute.md
Name: vliw_execute

Overview:
Execute/writeback stage of the 3-slot VLIW pipeline, directly downstream of decode; consumes the registered d2e_* bundle each cycle.
Owns the 16-entry architectural register file, applies one unary operation per slot to its destination register, and retires the bundle in one cycle.
Reports halt, illegal-opcode and intra-bundle write-conflict events; drives the flush request back to fetch/decode.

Parameters:
DATA_W, 64, register and immediate data width
NREG, 16, number of architectural registers; reg0 reads as zero
CNT_W, 32, width of the retired-instruction counter

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high
d2e_instpipe1/2/3  in  4 each  slot opcodes from decode
d2e_destpipe1/2/3  in  4 each  slot destination register indices
d2e_datapipe1/2/3  in  DATA_W each  slot immediates; meaningful for load only
dbg_addr  in  4  debug register-read index
dbg_data  out  DATA_W  registered debug read data
halted  out  1  sticky; set by a halt opcode
e2d_flush  out  1  flush request to fetch/decode; equals halted
illegal_op  out  1  one-cycle pulse: an undefined opcode was seen
wr_conflict  out  1  one-cycle pulse: two or more writing slots share a non-zero dest
retire_count  out  CNT_W  count of retired non-nop instructions

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset, evaluated only at a rising clock edge: all registers 0, dbg_data 0, halted 0, e2d_flush 0, illegal_op 0, wr_conflict 0, retire_count 0. Reset overrides every other event in the same cycle, including a mid-bundle halt.
- Opcodes: nop 0x0, load 0x1 (dest<=imm), inc 0x2 (+1), dec 0x3 (-1), not 0x4, shl 0x5 (<<1), shr 0x6 (logical >>1), clr 0x7 (dest<=0), halt 0xF. 0x8-0xE are illegal.
- Arithmetic is modulo 2^DATA_W: inc of all-ones gives 0; dec of 0 gives all-ones.
- Operands: every slot reads the register file state from the start of the cycle (VLIW read-before-write). Slots do not see each other's results in the same bundle.
- Latency: the result is written at the edge that samples the bundle. It is visible to the next bundle and to dbg_data one cycle later.
- reg0: writes are discarded; reads return 0.
- Writing slots are load, inc, dec, not, shl, shr and clr with dest != 0.
- Conflict: if two or more writing slots target the same dest, the highest-numbered slot wins (slot3 > slot2 > slot1) and wr_conflict pulses for 1 cycle.
- Illegal opcode: treated as nop (no write, not counted). illegal_op pulses for 1 cycle.
- Halt: halted and e2d_flush are set at that edge. Non-halt slots of the same bundle still execute and are counted; halt itself is counted. While halted, all inputs are ignored (no writes, no counts, no pulses) until reset.
- retire_count: adds the number of non-nop, legal slots in the bundle (0-3) each cycle. Wraps at 2^CNT_W.
- dbg_data <= regfile[dbg_addr] every cycle, reflecting state before the same-edge write.

Decomposition:
- Opcode constants (nop, load, inc, dec, not, shl, shr, clr, halt) and register names (reg0..reg15) go in the shared constant include, alongside the existing nop/load/reg0 definitions.
- One sub-module, vliw_alu_slot: a combinational unary ALU (opcode, operand, immediate -> result, writes, legal). Instantiate it three times.

Test Plan:
- Reset, then load r1=0x5, r2=0xA, r3=0xFF in one bundle -> next cycle dbg r1=5, r2=0xA, r3=0xFF; retire_count=3.
- Bundle {inc r1, dec r2, shl r3} after the above -> r1=6, r2=9, r3=0x1FE; no flags.
- Bundle {load r4=1, load r4=2, load r4=3} -> r4=3; wr_conflict pulses exactly 1 cycle.
- Read-before-write: r5=7, bundle {inc r5, load r6=0, not r5} -> r5=~7 (slot3 wins); conflict pulses.
- Opcode 0x9 on slot2 with load r7=0x11 on slot1 -> r7=0x11; illegal_op pulses; count +1. dec r0 -> r0 stays 0.
- {halt, load r8=0x22, nop} -> r8=0x22, halted=e2d_flush=1, count +2. Later loads are ignored. Reset clears halted and all registers at the next edge.
